// File: rtl/mem_arb_pkg.sv
// ============================================================================
// mem_arb_pkg : shared state encoding and owner IDs for mem_port_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS_I = 2'd1,
        BUS_D = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

endpackage

`default_nettype wire

// File: rtl/mem_arb_pick.sv
// ============================================================================
// mem_arb_pick : D-priority select with starvation override and its counter
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_arb_pick #(
    parameter int STARVE_MAX = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic i_req,
    input  logic d_req,
    input  logic grant,
    output logic pick_d
);

    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] r_starve_cnt;
    logic             w_starved;

    assign w_starved = (r_starve_cnt == CNT_W'(STARVE_MAX));
    assign pick_d    = d_req && !(i_req && w_starved);

    // Counts D-wins taken while the fetch port was waiting; any I-win clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (grant) begin
            if (!pick_d) begin
                r_starve_cnt <= '0;
            end else if (i_req && !w_starved) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter : shares one memory port between fetch (I) and data (D)
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ack,
    output logic              busy,
    output logic              owner_d
);

    state_t r_state;
    logic   w_grant;
    logic   w_pick_d;

    assign w_grant = (r_state == IDLE) && (i_req || d_req);

    mem_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .clk    (clk),
        .reset  (reset),
        .i_req  (i_req),
        .d_req  (d_req),
        .grant  (w_grant),
        .pick_d (w_pick_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            i_rdata <= '0;
            d_rdata <= '0;
            i_ack   <= 1'b0;
            d_ack   <= 1'b0;
            busy    <= 1'b0;
            owner_d <= OWN_I;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        m_req <= 1'b1;
                        busy  <= 1'b1;
                        if (w_pick_d) begin
                            r_state <= BUS_D;
                            owner_d <= OWN_D;
                            m_we    <= d_we;
                            m_addr  <= d_addr;
                            m_wdata <= d_wdata;
                        end else begin
                            r_state <= BUS_I;
                            owner_d <= OWN_I;
                            m_we    <= 1'b0;
                            m_addr  <= i_addr;
                            m_wdata <= '0;
                        end
                    end
                end
                BUS_I, BUS_D: begin
                    // Store responses still load d_rdata; the value is simply unused.
                    if (m_ack) begin
                        m_req   <= 1'b0;
                        r_state <= RESP;
                        if (r_state == BUS_D) begin
                            d_rdata <= m_rdata;
                            d_ack   <= 1'b1;
                        end else begin
                            i_rdata <= m_rdata;
                            i_ack   <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                    owner_d <= OWN_I;
                end
                default: begin
                    r_state <= IDLE;
                    m_req   <= 1'b0;
                    busy    <= 1'b0;
                    owner_d <= OWN_I;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter : directed table-driven bench for mem_port_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we, m_ack;
    logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
    logic        i_ack, d_ack, m_req, m_we, busy, owner_d;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_i_rdata = '0;
    logic [31:0] exp_d_rdata = '0;

    typedef struct {
        logic        ir, dr, we;
        logic [31:0] ia, da, wd, rd;
        int          dly;
        logic        exp_d;
        logic [31:0] exp_addr;
        logic        exp_we;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[11];

    mem_port_arbiter dut (
        .clk     (clk),
        .reset   (reset),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_rdata (i_rdata),
        .i_ack   (i_ack),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_rdata (d_rdata),
        .d_ack   (d_ack),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .m_ack   (m_ack),
        .busy    (busy),
        .owner_d (owner_d)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ir, input logic dr, input logic we,
                                input logic [31:0] ia, input logic [31:0] da,
                                input logic [31:0] wd, input logic [31:0] rd,
                                input int dly, input logic exp_d,
                                input logic [31:0] exp_addr, input logic exp_we,
                                input logic [31:0] exp_wdata);
        vec_t v;
        v.ir = ir; v.dr = dr; v.we = we; v.ia = ia; v.da = da; v.wd = wd;
        v.rd = rd; v.dly = dly; v.exp_d = exp_d; v.exp_addr = exp_addr;
        v.exp_we = exp_we; v.exp_wdata = exp_wdata;
        return v;
    endfunction

    task automatic run_txn(input vec_t v, input int idx);
        int lat;
        @(negedge clk);
        i_req = v.ir; d_req = v.dr; d_we = v.we;
        i_addr = v.ia; d_addr = v.da; d_wdata = v.wd;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!m_req && lat < 10);
        chk($sformatf("v%0d_grant_latency", idx), 32'(lat), 32'd1);
        chk($sformatf("v%0d_owner_d", idx), 32'(owner_d), 32'(v.exp_d));
        chk($sformatf("v%0d_m_addr", idx), m_addr, v.exp_addr);
        chk($sformatf("v%0d_m_we", idx), 32'(m_we), 32'(v.exp_we));
        if (v.exp_we) chk($sformatf("v%0d_m_wdata", idx), m_wdata, v.exp_wdata);
        for (int c = 1; c < v.dly; c++) begin
            @(negedge clk);
            chk($sformatf("v%0d_hold_m_req", idx), 32'(m_req), 32'd1);
            chk($sformatf("v%0d_hold_m_addr", idx), m_addr, v.exp_addr);
            if (v.exp_we) chk($sformatf("v%0d_hold_m_wdata", idx), m_wdata, v.exp_wdata);
        end
        m_rdata = v.rd;
        m_ack   = 1'b1;
        @(negedge clk);
        m_ack = 1'b0;
        if (v.exp_d) exp_d_rdata = v.rd;
        else         exp_i_rdata = v.rd;
        chk($sformatf("v%0d_i_ack", idx), 32'(i_ack), 32'(!v.exp_d));
        chk($sformatf("v%0d_d_ack", idx), 32'(d_ack), 32'(v.exp_d));
        chk($sformatf("v%0d_i_rdata", idx), i_rdata, exp_i_rdata);
        chk($sformatf("v%0d_d_rdata", idx), d_rdata, exp_d_rdata);
        chk($sformatf("v%0d_m_req_dropped", idx), 32'(m_req), 32'd0);
        chk($sformatf("v%0d_busy_resp", idx), 32'(busy), 32'd1);
        i_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d_ack_one_cycle", idx), 32'({i_ack, d_ack}), 32'd0);
        chk($sformatf("v%0d_busy_after", idx), 32'(busy), 32'd0);
    endtask

    initial begin
        // Directed table: I fetch, D store, D load, then 8 back-to-back ties.
        vecs[0]  = mk(1, 0, 0, 32'h0000_0040, 32'h0,         32'h0,         32'h2402_0005, 2, 0, 32'h0000_0040, 0, 32'h0);
        vecs[1]  = mk(0, 1, 1, 32'h0,         32'h0000_0100, 32'hDEAD_BEEF, 32'h5555_AAAA, 3, 1, 32'h0000_0100, 1, 32'hDEAD_BEEF);
        vecs[2]  = mk(0, 1, 0, 32'h0,         32'h0000_0200, 32'h0,         32'h1234_5678, 1, 1, 32'h0000_0200, 0, 32'h0);
        vecs[3]  = mk(1, 1, 0, 32'h0000_1000, 32'h0000_2000, 32'h0,         32'hA000_0000, 1, 1, 32'h0000_2000, 0, 32'h0);
        vecs[4]  = mk(1, 1, 0, 32'h0000_1004, 32'h0000_2004, 32'h0,         32'hA000_0001, 2, 1, 32'h0000_2004, 0, 32'h0);
        vecs[5]  = mk(1, 1, 0, 32'h0000_1008, 32'h0000_2008, 32'h0,         32'hA000_0002, 1, 1, 32'h0000_2008, 0, 32'h0);
        vecs[6]  = mk(1, 1, 0, 32'h0000_100C, 32'h0000_200C, 32'h0,         32'hA000_0003, 2, 0, 32'h0000_100C, 0, 32'h0);
        vecs[7]  = mk(1, 1, 0, 32'h0000_1010, 32'h0000_2010, 32'h0,         32'hA000_0004, 1, 1, 32'h0000_2010, 0, 32'h0);
        vecs[8]  = mk(1, 1, 0, 32'h0000_1014, 32'h0000_2014, 32'h0,         32'hA000_0005, 2, 1, 32'h0000_2014, 0, 32'h0);
        vecs[9]  = mk(1, 1, 0, 32'h0000_1018, 32'h0000_2018, 32'h0,         32'hA000_0006, 1, 1, 32'h0000_2018, 0, 32'h0);
        vecs[10] = mk(1, 1, 0, 32'h0000_101C, 32'h0000_201C, 32'h0,         32'hA000_0007, 2, 0, 32'h0000_101C, 0, 32'h0);

        reset = 1'b1;
        i_req = 1'b0; d_req = 1'b1; d_we = 1'b0;
        i_addr = '0; d_addr = 32'h0000_0300; d_wdata = '0;
        m_ack = 1'b0; m_rdata = '0;

        // Reset held 100 ns with a pending D request: nothing may move.
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("rst_m_req", 32'(m_req), 32'd0);
            chk("rst_outs", 32'({m_we, i_ack, d_ack, busy, owner_d}), 32'd0);
            chk("rst_m_addr", m_addr | m_wdata | i_rdata | d_rdata, 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_m_req", 32'(m_req), 32'd1);
        chk("post_rst_m_addr", m_addr, 32'h0000_0300);
        m_rdata = 32'h0BAD_F00D; m_ack = 1'b1;
        @(negedge clk);
        m_ack = 1'b0;
        chk("post_rst_d_ack", 32'(d_ack), 32'd1);
        chk("post_rst_d_rdata", d_rdata, 32'h0BAD_F00D);
        exp_d_rdata = 32'h0BAD_F00D;
        d_req = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 11; i++) run_txn(vecs[i], i);

        // Spurious m_ack while idle must be ignored.
        @(negedge clk);
        m_rdata = 32'hBAD0_BAD0; m_ack = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("spur_acks", 32'({i_ack, d_ack}), 32'd0);
            chk("spur_busy", 32'(busy), 32'd0);
            chk("spur_m_req", 32'(m_req), 32'd0);
            chk("spur_i_rdata", i_rdata, exp_i_rdata);
            chk("spur_d_rdata", d_rdata, exp_d_rdata);
        end
        m_ack = 1'b0;

        // Async reset mid-BUS_D, then a late m_ack.
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0400;
        @(negedge clk);
        chk("ar_m_req_up", 32'(m_req), 32'd1);
        chk("ar_owner_d", 32'(owner_d), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("ar_m_req_async", 32'(m_req), 32'd0);
        chk("ar_busy_async", 32'(busy), 32'd0);
        d_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        m_rdata = 32'h7777_7777; m_ack = 1'b1;
        @(negedge clk);
        m_ack = 1'b0;
        chk("ar_late_acks", 32'({i_ack, d_ack}), 32'd0);
        chk("ar_late_busy", 32'(busy), 32'd0);
        chk("ar_late_m_req", 32'(m_req), 32'd0);
        chk("ar_late_d_rdata", d_rdata, 32'd0);
        @(negedge clk);
        chk("ar_late_busy2", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
